// File: rtl/block_fetch_ctrl.sv
// rtl/block_fetch_ctrl.sv - search-block fetch sequencer, frame SRAM -> search-window buffer
// Optional BLOCK_FETCH_PERF_EN adds the stall_cnt output (ungranted ISSUE cycles).
module block_fetch_ctrl #(
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 48,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int WIN_DIM    = 12,
  parameter int WIN_ADDR_W = 8,
  localparam int ROW_W     = $clog2(FRAME_H),
  localparam int COL_W     = $clog2(FRAME_W),
  localparam int CNT_W     = $clog2(WIN_DIM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_W-1:0]      base_row,
  input  logic [COL_W-1:0]      base_col,
  input  logic [CNT_W-1:0]      size_row,
  input  logic [CNT_W-1:0]      size_col,
  input  logic [CNT_W-1:0]      pad_row,
  input  logic [CNT_W-1:0]      pad_col,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_gnt,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  win_we,
  output logic [WIN_ADDR_W-1:0] win_addr,
  output logic [DATA_W-1:0]     win_wdata
`ifdef BLOCK_FETCH_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ROW_W-1:0]      base_row_q, base_row_d;
  logic [COL_W-1:0]      base_col_q, base_col_d;
  logic [CNT_W-1:0]      size_row_q, size_row_d;
  logic [CNT_W-1:0]      size_col_q, size_col_d;
  logic [CNT_W-1:0]      pad_row_q, pad_row_d;
  logic [CNT_W-1:0]      pad_col_q, pad_col_d;
  logic [CNT_W-1:0]      r_q, r_d;
  logic [CNT_W-1:0]      c_q, c_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q;
  logic [WIN_ADDR_W-1:0] waddr_q;

  logic                  beat;
  logic                  last_c;
  logic                  last_r;
  logic [CNT_W:0]        row_end;
  logic [CNT_W:0]        col_end;
  logic                  req_ovf;
  logic                  req_empty;
  logic [ADDR_W-1:0]     frame_row;
  logic [ADDR_W-1:0]     addr_c;
  logic [WIN_ADDR_W-1:0] waddr_c;

  assign mem_req = (state_q == ISSUE);
  assign beat    = mem_req && mem_gnt;
  assign last_c  = (c_q == size_col_q - CNT_W'(1));
  assign last_r  = (r_q == size_row_q - CNT_W'(1));

  // One extra bit so pad+size cannot wrap before the window-edge compare.
  assign row_end   = (CNT_W+1)'(pad_row) + (CNT_W+1)'(size_row);
  assign col_end   = (CNT_W+1)'(pad_col) + (CNT_W+1)'(size_col);
  assign req_ovf   = (row_end > (CNT_W+1)'(WIN_DIM)) || (col_end > (CNT_W+1)'(WIN_DIM));
  assign req_empty = (size_row == '0) || (size_col == '0);

  assign frame_row = ADDR_W'(base_row_q) + ADDR_W'(r_q);
  assign addr_c    = frame_row * ADDR_W'(FRAME_W) + ADDR_W'(base_col_q) + ADDR_W'(c_q);
  assign waddr_c   = (WIN_ADDR_W'(pad_row_q) + WIN_ADDR_W'(r_q)) * WIN_ADDR_W'(WIN_DIM)
                     + WIN_ADDR_W'(pad_col_q) + WIN_ADDR_W'(c_q);

  always_comb begin
    state_d    = state_q;
    base_row_d = base_row_q;
    base_col_d = base_col_q;
    size_row_d = size_row_q;
    size_col_d = size_col_q;
    pad_row_d  = pad_row_q;
    pad_col_d  = pad_col_q;
    r_d        = r_q;
    c_d        = c_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_row_d = base_row;
          base_col_d = base_col;
          size_row_d = size_row;
          size_col_d = size_col;
          pad_row_d  = pad_row;
          pad_col_d  = pad_col;
          r_d        = '0;
          c_d        = '0;
          ovf_d      = req_ovf;
          // Rejected requests still pass through DRAIN so done keeps the
          // size_row*size_col+2 timing even with zero beats.
          state_d    = (req_ovf || req_empty) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          if (last_c) begin
            c_d = '0;
            if (last_r) begin
              state_d = DRAIN;
            end else begin
              r_d = r_q + CNT_W'(1);
            end
          end else begin
            c_d = c_q + CNT_W'(1);
          end
        end
      end
      DRAIN:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_row_q <= '0;
      base_col_q <= '0;
      size_row_q <= '0;
      size_col_q <= '0;
      pad_row_q  <= '0;
      pad_col_q  <= '0;
      r_q        <= '0;
      c_q        <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_row_q <= base_row_d;
      base_col_q <= base_col_d;
      size_row_q <= size_row_d;
      size_col_q <= size_col_d;
      pad_row_q  <= pad_row_d;
      pad_col_q  <= pad_col_d;
      r_q        <= r_d;
      c_q        <= c_d;
      ovf_q      <= ovf_d;
      valid_q    <= beat;
      if (beat) begin
        waddr_q <= waddr_c;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err_ovf   = done && ovf_q;
  assign mem_addr  = mem_req ? addr_c : '0;
  assign win_we    = valid_q;
  assign win_addr  = valid_q ? waddr_q : '0;
  assign win_wdata = valid_q ? mem_rdata : '0;

`ifdef BLOCK_FETCH_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (mem_req && !mem_gnt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_block_fetch_ctrl.sv
// tb/tb_block_fetch_ctrl.sv - directed bench for block_fetch_ctrl
// Define BLOCK_FETCH_PERF_EN to include the stall_cnt port and its check.
module tb_block_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_row, base_col;
  logic [3:0]  size_row, size_col, pad_row, pad_col;
  logic        busy, done, err_ovf, mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rdata = 8'h00;
  logic        win_we;
  logic [7:0]  win_addr;
  logic [7:0]  win_wdata;
`ifdef BLOCK_FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int gnt_rand = 0;
  logic [11:0] beat_q[$];
  logic [7:0]  wa_q[$];
  logic [7:0]  wd_q[$];
  int done_n, err_n, req_n, stall_n;

  always #5 clk = ~clk;

  block_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_row(base_row), .base_col(base_col),
    .size_row(size_row), .size_col(size_col),
    .pad_row(pad_row), .pad_col(pad_col),
    .busy(busy), .done(done), .err_ovf(err_ovf),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .win_we(win_we), .win_addr(win_addr), .win_wdata(win_wdata)
`ifdef BLOCK_FETCH_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [7:0] pix(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  // SRAM model: data for a transferred beat appears the following cycle.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_rdata <= pix(mem_addr);
    else                    mem_rdata <= 8'hEE;
  end

  always @(posedge clk) begin
    if (gnt_rand != 0) begin
      #1 mem_gnt = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (mem_req && mem_gnt) beat_q.push_back(mem_addr);
    if (mem_req) begin
      req_n++;
      if (!mem_gnt) stall_n++;
    end
    if (win_we) begin
      wa_q.push_back(win_addr);
      wd_q.push_back(win_wdata);
    end
    if (done) begin
      done_n++;
      if (err_ovf) err_n++;
    end
  end

  task automatic clr();
    beat_q.delete(); wa_q.delete(); wd_q.delete();
    done_n = 0; err_n = 0; req_n = 0; stall_n = 0;
  endtask

  task automatic set_in(input int br, bc, sr, sc, pr, pc);
    base_row = 6'(br); base_col = 6'(bc);
    size_row = 4'(sr); size_col = 4'(sc);
    pad_row  = 4'(pr); pad_col  = 4'(pc);
  endtask

  // lat = number of the edge after the start edge that samples done high.
  task automatic fetch(input int br, bc, sr, sc, pr, pc, output int lat);
    int k;
    @(posedge clk); #1;
    set_in(br, bc, sr, sc, pr, pc);
    clr();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    lat = k;
    @(posedge clk); #1;
  endtask

  // Counts mismatches between recorded traffic and a raster-order model.
  function automatic int mism(input int br, bc, sr, sc, pr, pc);
    int bad = 0;
    if (beat_q.size() != sr * sc) bad++;
    if (wa_q.size() != sr * sc) bad++;
    for (int r = 0; r < sr; r++) begin
      for (int c = 0; c < sc; c++) begin
        int i;
        logic [11:0] ea;
        logic [7:0]  ew;
        i  = r * sc + c;
        ea = 12'((br + r) * 64 + bc + c);
        ew = 8'((pr + r) * 12 + pc + c);
        if (i < beat_q.size() && beat_q[i] !== ea) bad++;
        if (i < wa_q.size()) begin
          if (wa_q[i] !== ew) bad++;
          if (wd_q[i] !== pix(ea)) bad++;
        end
      end
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mem_gnt = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #12;
    n_chk++;
    if ({busy, done, err_ovf, mem_req, mem_addr, win_we, win_addr, win_wdata} !== '0)
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, err_ovf, mem_req, mem_addr, win_we, win_addr, win_wdata});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_full_window();
    int lat, bad;
    logic [11:0] fa, la;
    fetch(8, 16, 12, 12, 0, 0, lat);
    bad = mism(8, 16, 12, 12, 0, 0);
    fa = (beat_q.size() > 0) ? beat_q[0] : 12'hFFF;
    la = (beat_q.size() > 0) ? beat_q[beat_q.size()-1] : 12'hFFF;
    n_chk++; if (lat !== 146) $display("FAIL full_latency: got %0d expected 146", lat); else n_pass++;
    n_chk++; if (beat_q.size() !== 144) $display("FAIL full_beats: got %0d expected 144", beat_q.size()); else n_pass++;
    n_chk++; if (fa !== 12'd528) $display("FAIL full_first_addr: got %0d expected 528", fa); else n_pass++;
    n_chk++; if (la !== 12'd1243) $display("FAIL full_last_addr: got %0d expected 1243", la); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL full_traffic: got %0d mismatches expected 0", bad); else n_pass++;
    n_chk++; if (err_n !== 0 || done_n !== 1) $display("FAIL full_done: got done=%0d err=%0d expected 1/0", done_n, err_n); else n_pass++;
  endtask

  task automatic test_padded();
    int lat, bad;
    logic [7:0] fw, lw;
    logic [11:0] la;
    fetch(0, 0, 10, 10, 2, 2, lat);
    bad = mism(0, 0, 10, 10, 2, 2);
    fw = (wa_q.size() > 0) ? wa_q[0] : 8'hFF;
    lw = (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 8'hFF;
    la = (beat_q.size() > 0) ? beat_q[beat_q.size()-1] : 12'hFFF;
    n_chk++; if (fw !== 8'd26) $display("FAIL pad_first_win: got %0d expected 26", fw); else n_pass++;
    n_chk++; if (lw !== 8'd143) $display("FAIL pad_last_win: got %0d expected 143", lw); else n_pass++;
    n_chk++; if (la !== 12'd585) $display("FAIL pad_last_addr: got %0d expected 585", la); else n_pass++;
    n_chk++; if (lat !== 102) $display("FAIL pad_latency: got %0d expected 102", lat); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL pad_traffic: got %0d mismatches expected 0", bad); else n_pass++;
  endtask

  task automatic test_grant_stalls();
    int lat, bad, nonmono;
    gnt_rand = 1;
    fetch(40, 52, 2, 12, 0, 0, lat);
    gnt_rand = 0;
    mem_gnt = 1'b1;
    bad = mism(40, 52, 2, 12, 0, 0);
    nonmono = 0;
    for (int i = 1; i < wa_q.size(); i++) if (wa_q[i] <= wa_q[i-1]) nonmono++;
    n_chk++; if (wa_q.size() !== 24) $display("FAIL stall_writes: got %0d expected 24", wa_q.size()); else n_pass++;
    n_chk++; if (nonmono !== 0) $display("FAIL stall_monotonic: got %0d reversals expected 0", nonmono); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL stall_traffic: got %0d mismatches expected 0", bad); else n_pass++;
    n_chk++; if (lat !== 24 + stall_n + 2) $display("FAIL stall_latency: got %0d expected %0d", lat, 24 + stall_n + 2); else n_pass++;
`ifdef BLOCK_FETCH_PERF_EN
    n_chk++; if (stall_cnt !== 16'(stall_n)) $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, stall_n); else n_pass++;
`endif
  endtask

  task automatic test_rejects();
    int lat;
    fetch(5, 5, 4, 0, 0, 0, lat);
    n_chk++; if (lat !== 2) $display("FAIL rej_empty_latency: got %0d expected 2", lat); else n_pass++;
    n_chk++; if (req_n !== 0 || err_n !== 0) $display("FAIL rej_empty_flags: got req=%0d err=%0d expected 0/0", req_n, err_n); else n_pass++;
    fetch(0, 0, 4, 10, 0, 3, lat);
    n_chk++; if (lat !== 2) $display("FAIL rej_ovf_latency: got %0d expected 2", lat); else n_pass++;
    n_chk++; if (req_n !== 0 || err_n !== 1) $display("FAIL rej_ovf_flags: got req=%0d err=%0d expected 0/1", req_n, err_n); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int bad;
    @(posedge clk); #1;
    set_in(1, 2, 3, 4, 0, 0);
    clr();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_in(30, 30, 1, 1, 5, 5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    bad = mism(1, 2, 3, 4, 0, 0);
    n_chk++; if (bad !== 0) $display("FAIL busy_traffic: got %0d mismatches expected 0", bad); else n_pass++;
    n_chk++; if (done_n !== 1) $display("FAIL busy_done_count: got %0d expected 1", done_n); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    int lat, nw, bad, k;
    @(posedge clk); #1;
    set_in(8, 16, 12, 12, 0, 0);
    clr();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 100 && beat_q.size() < 20; k++) @(negedge clk);
    n_chk++; if (beat_q.size() < 20) $display("FAIL rst_mid_progress: got %0d beats expected 20", beat_q.size()); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, err_ovf, mem_req, mem_addr, win_we, win_addr, win_wdata} !== '0)
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {busy, done, err_ovf, mem_req, mem_addr, win_we, win_addr, win_wdata});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nw = wa_q.size();
    repeat (5) @(negedge clk);
    n_chk++; if (wa_q.size() !== nw) $display("FAIL rst_mid_no_write: got %0d writes expected %0d", wa_q.size(), nw); else n_pass++;
    fetch(3, 4, 2, 2, 1, 1, lat);
    bad = mism(3, 4, 2, 2, 1, 1);
    n_chk++; if (lat !== 6 || bad !== 0) $display("FAIL rst_mid_next_fetch: got lat=%0d bad=%0d expected 6/0", lat, bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_padded();
    test_grant_stalls();
    test_rejects();
    test_start_while_busy();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
